// File: rtl/fpadd_sequencer_if.sv
// Bundle of request, datapath-control and response signals around the FP adder sequencer.
interface fpadd_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req_a0;
   logic [WIDTH-1:0] req_b0;
   logic [WIDTH-1:0] req_a1;
   logic [WIDTH-1:0] req_b1;
   logic [WIDTH-1:0] dp_opA;
   logic [WIDTH-1:0] dp_opB;
   logic             dp_load;
   logic             dp_bypass;
   logic             dp_alu_en;
   logic             dp_norm_start;
   logic             dp_norm_done;
   logic             dp_round_en;
   logic [WIDTH-1:0] dp_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_id;
   logic             rsp_error;
   logic             busy;

   // Sequencer side.
   modport master (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, dp_norm_done, dp_result, rsp_ready,
      output req_ready, dp_opA, dp_opB, dp_load, dp_bypass, dp_alu_en, dp_norm_start,
             dp_round_en, rsp_valid, rsp_result, rsp_id, rsp_error, busy
   );

   // Requesters, datapath and response consumer side.
   modport slave (
      output req_valid, req_a0, req_b0, req_a1, req_b1, dp_norm_done, dp_result, rsp_ready,
      input  req_ready, dp_opA, dp_opB, dp_load, dp_bypass, dp_alu_en, dp_norm_start,
             dp_round_en, rsp_valid, rsp_result, rsp_id, rsp_error, busy
   );
endinterface

// File: rtl/fpadd_sequencer.sv
// Sequencer for the shared FP adder datapath: round-robin arbitration of two requesters,
// stage-enable sequencing with special-operand bypass, and tagged response return.
module fpadd_sequencer #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned EXP_W        = 8,
   parameter int unsigned NORM_TIMEOUT = 31
) (
   input  logic              clock,
   input  logic              reset,
   fpadd_sequencer_if.master bus
);
   localparam int unsigned      CNT_W   = $clog2(NORM_TIMEOUT + 1);
   localparam logic [WIDTH-1:0] QNAN    = WIDTH'(32'h7FC0_0000);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NORM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ALU, S_NORM, S_ROUND, S_BYPASS, S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             id_q, id_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_q, load_d;
   logic             bypass_q, bypass_d;
   logic             alu_en_q, alu_en_d;
   logic             norm_start_q, norm_start_d;
   logic             round_en_q, round_en_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

   logic             grant_c;
   logic [1:0]       ready_c;
   logic             handshake_c;
   logic [EXP_W-1:0] exp_a_c, exp_b_c;
   logic             special_c;

   // Round-robin grant; ready is held low during reset so every output reads 0.
   always_comb begin
      grant_c = bus.req_valid[1];
      if (bus.req_valid == 2'b11) grant_c = ~last_grant_q;
      ready_c = 2'b00;
      if ((state_q == S_IDLE) && !reset && (bus.req_valid != 2'b00))
         ready_c = grant_c ? 2'b10 : 2'b01;
   end

   assign handshake_c = |(ready_c & bus.req_valid);

   // Zero/denormal and Inf/NaN operands skip the arithmetic stages.
   assign exp_a_c   = op_a_q[WIDTH-2 -: EXP_W];
   assign exp_b_c   = op_b_q[WIDTH-2 -: EXP_W];
   assign special_c = (exp_a_c == '0) || (exp_a_c == '1) ||
                      (exp_b_c == '0) || (exp_b_c == '1);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      id_d         = id_q;
      result_d     = result_q;
      error_d      = error_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (handshake_c) begin
               state_d      = S_LOAD;
               last_grant_d = grant_c;
               id_d         = grant_c;
               op_a_d       = grant_c ? bus.req_a1 : bus.req_a0;
               op_b_d       = grant_c ? bus.req_b1 : bus.req_b0;
            end
         end
         S_LOAD:  state_d = special_c ? S_BYPASS : S_ALU;
         S_ALU:   state_d = S_NORM;
         S_NORM: begin
            if (bus.dp_norm_done) begin
               state_d = S_ROUND;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = S_RESP;
               result_d = QNAN;
               error_d  = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ROUND, S_BYPASS: begin
            state_d  = S_RESP;
            result_d = bus.dp_result;
            error_d  = 1'b0;
         end
         S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Stage controls are registered, so they are decoded from the next state.
      load_d       = (state_d == S_LOAD);
      bypass_d     = (state_d == S_BYPASS);
      alu_en_d     = (state_d == S_ALU);
      norm_start_d = (state_d == S_NORM) && (state_q != S_NORM);
      round_en_d   = (state_d == S_ROUND);
      rsp_valid_d  = (state_d == S_RESP);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_a_q       <= '0;
         op_b_q       <= '0;
         result_q     <= '0;
         id_q         <= 1'b0;
         error_q      <= 1'b0;
         cnt_q        <= '0;
         load_q       <= 1'b0;
         bypass_q     <= 1'b0;
         alu_en_q     <= 1'b0;
         norm_start_q <= 1'b0;
         round_en_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         result_q     <= result_d;
         id_q         <= id_d;
         error_q      <= error_d;
         cnt_q        <= cnt_d;
         load_q       <= load_d;
         bypass_q     <= bypass_d;
         alu_en_q     <= alu_en_d;
         norm_start_q <= norm_start_d;
         round_en_q   <= round_en_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready     = ready_c;
   assign bus.dp_opA        = op_a_q;
   assign bus.dp_opB        = op_b_q;
   assign bus.dp_load       = load_q;
   assign bus.dp_bypass     = bypass_q;
   assign bus.dp_alu_en     = alu_en_q;
   assign bus.dp_norm_start = norm_start_q;
   assign bus.dp_round_en   = round_en_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_result    = result_q;
   assign bus.rsp_id        = id_q;
   assign bus.rsp_error     = error_q;
   assign bus.busy          = busy_q;
endmodule
